// File: rtl/assoc_cache.sv
// assoc_cache -- fully-associative, write-through, write-allocate cache
// placed between the processor memory stage and the RAM model.
//
// Every entry stores the full address as its tag. Replacement picks the
// lowest-index invalid way first, and otherwise the least recently used way.
// LRU order is held as per-way ages that always form a permutation of
// 0..WAYS-1. Because the cache is write-through, RAM is always coherent and
// an eviction never needs a write-back.
//
// Parameters:
//   ADDR_W  address width (also the tag width)
//   DATA_W  data word width
//   WAYS    number of entries (power of two, >= 2)
//   CNT_W   width of the saturating hit/miss counters
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_rd / cpu_wr       level requests, held until cpu_ready
//   cpu_flush             invalidate all entries
//   cpu_addr, cpu_wdata   request address and write data
//   cpu_rdata, cpu_ready  read data (held) and one-cycle completion pulse
//   mem_addr, mem_wdata   RAM address and write data
//   mem_ce, mem_rw        RAM request (held until mem_ack); 1 = read
//   mem_rdata, mem_ack    RAM read data and one-cycle completion pulse
//   hit_count, miss_count saturating statistics counters
module assoc_cache #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int WAYS   = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic              cpu_flush,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ce,
   output logic              mem_rw,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [AGE_W-1:0] AGE_OLDEST = AGE_W'(WAYS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WBACK = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                valid_q [WAYS];
   logic                valid_d [WAYS];
   logic [ADDR_W-1:0]   tag_q   [WAYS];
   logic [ADDR_W-1:0]   tag_d   [WAYS];
   logic [DATA_W-1:0]   data_q  [WAYS];
   logic [DATA_W-1:0]   data_d  [WAYS];
   logic [AGE_W-1:0]    age_q   [WAYS];
   logic [AGE_W-1:0]    age_d   [WAYS];

   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic                cpu_ready_q, cpu_ready_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_ce_q, mem_ce_d;
   logic                mem_rw_q, mem_rw_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

   logic                hit;
   logic [AGE_W-1:0]    hit_idx;
   logic                inv_found;
   logic [AGE_W-1:0]    inv_idx;
   logic [AGE_W-1:0]    lru_idx;
   logic [AGE_W-1:0]    victim_idx;
   logic                lru_en;
   logic [AGE_W-1:0]    lru_way;

   // Tag match against the live request address. Tags are unique, so at most
   // one way can match and the loop order does not matter.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (valid_q[i] && (tag_q[i] == cpu_addr)) begin
            hit     = 1'b1;
            hit_idx = AGE_W'(i);
         end
      end
   end

   // Victim is computed from the current (pre-update) state.
   always_comb begin
      inv_found = 1'b0;
      inv_idx   = '0;
      lru_idx   = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (!valid_q[i] && !inv_found) begin
            inv_found = 1'b1;
            inv_idx   = AGE_W'(i);
         end
         if (age_q[i] == AGE_OLDEST) begin
            lru_idx = AGE_W'(i);
         end
      end
      victim_idx = inv_found ? inv_idx : lru_idx;
   end

   // Next-state logic for the FSM and all datapath registers.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      age_d       = age_q;
      cpu_rdata_d = cpu_rdata_q;
      cpu_ready_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_ce_d    = mem_ce_q;
      mem_rw_d    = mem_rw_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      lru_en      = 1'b0;
      lru_way     = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (cpu_flush) begin
               for (int i = 0; i < WAYS; i++) begin
                  valid_d[i] = 1'b0;
               end
               cpu_ready_d = 1'b1;
            end else if (cpu_wr) begin
               if (hit) begin
                  data_d[hit_idx] = cpu_wdata;
                  lru_en          = 1'b1;
                  lru_way         = hit_idx;
                  hit_cnt_d       = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
               end else begin
                  valid_d[victim_idx] = 1'b1;
                  tag_d[victim_idx]   = cpu_addr;
                  data_d[victim_idx]  = cpu_wdata;
                  lru_en              = 1'b1;
                  lru_way             = victim_idx;
                  miss_cnt_d          = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
               end
               mem_ce_d    = 1'b1;
               mem_rw_d    = 1'b0;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               state_d     = ST_WBACK;
            end else if (cpu_rd) begin
               if (hit) begin
                  cpu_rdata_d = data_q[hit_idx];
                  cpu_ready_d = 1'b1;
                  lru_en      = 1'b1;
                  lru_way     = hit_idx;
                  hit_cnt_d   = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
               end else begin
                  mem_ce_d   = 1'b1;
                  mem_rw_d   = 1'b1;
                  mem_addr_d = cpu_addr;
                  miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
                  state_d    = ST_FILL;
               end
            end
         end

         ST_FILL: begin
            // mem_addr_q still holds the missing address and serves as the tag.
            if (mem_ack) begin
               valid_d[victim_idx] = 1'b1;
               tag_d[victim_idx]   = mem_addr_q;
               data_d[victim_idx]  = mem_rdata;
               lru_en              = 1'b1;
               lru_way             = victim_idx;
               cpu_rdata_d         = mem_rdata;
               cpu_ready_d         = 1'b1;
               mem_ce_d            = 1'b0;
               state_d             = ST_IDLE;
            end
         end

         ST_WBACK: begin
            if (mem_ack) begin
               cpu_ready_d = 1'b1;
               mem_ce_d    = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Touching a way makes it youngest; only ways younger than it age, so
      // the ages remain a permutation.
      if (lru_en) begin
         for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] < age_q[lru_way]) begin
               age_d[i] = age_q[i] + 1'b1;
            end
         end
         age_d[lru_way] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         for (int i = 0; i < WAYS; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
            age_q[i]   <= AGE_W'(i);
         end
         cpu_rdata_q <= '0;
         cpu_ready_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_ce_q    <= 1'b0;
         mem_rw_q    <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
         age_q       <= age_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ready_q <= cpu_ready_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_ce_q    <= mem_ce_d;
         mem_rw_q    <= mem_rw_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_ready  = cpu_ready_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_ce     = mem_ce_q;
   assign mem_rw     = mem_rw_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed testbench for assoc_cache. A default-parameter instance is paired
// with a CNT_W=2 instance fed by identical inputs for the saturation case.
// A small RAM responder answers mem_ce after a programmable delay.
module tb_assoc_cache;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_rd, cpu_wr, cpu_flush;
   logic [7:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ce, mem_rw;
   logic        mem_ack;
   logic [15:0] hit_count, miss_count;

   logic [31:0] s_cpu_rdata;
   logic        s_cpu_ready;
   logic [7:0]  s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic        s_mem_ce, s_mem_rw;
   logic [1:0]  s_hit_count, s_miss_count;

   int checks = 0;
   int errors = 0;
   int ack_dly = 3;

   logic [31:0] ram [256];
   int          wait_cnt;

   always #5 clk = ~clk;

   assoc_cache #(.ADDR_W(8), .DATA_W(32), .WAYS(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_flush(cpu_flush),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ce(mem_ce), .mem_rw(mem_rw), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   assoc_cache #(.ADDR_W(8), .DATA_W(32), .WAYS(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_flush(cpu_flush),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(s_cpu_rdata), .cpu_ready(s_cpu_ready),
      .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
      .mem_ce(s_mem_ce), .mem_rw(s_mem_rw), .mem_ack(mem_ack),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   // RAM responder: contents reload on reset; ack follows mem_ce rising by
   // ack_dly-1 cycles, so mem_ce stays high for ack_dly cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) begin
            ram[i] <= 32'hA5A5_0000 | i;
         end
         ram[8'h20] <= 32'hDEAD_BEEF;
         mem_ack    <= 1'b0;
         mem_rdata  <= '0;
         wait_cnt   <= 0;
      end else begin
         mem_ack <= 1'b0;
         if (mem_ce && !mem_ack) begin
            if (wait_cnt >= ack_dly - 2) begin
               mem_ack   <= 1'b1;
               mem_rdata <= ram[mem_addr];
               if (!mem_rw) begin
                  ram[mem_addr] <= mem_wdata;
               end
               wait_cnt <= 0;
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end
      end
   end

   task automatic apply_reset();
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_flush = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue a read and wait for cpu_ready; lat counts edges from request to
   // ready, ce_cyc counts cycles with mem_ce high.
   task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                          output int lat, output int ce_cyc);
      bit done = 0;
      @(negedge clk);
      cpu_rd   = 1'b1;
      cpu_addr = a;
      lat      = 0;
      ce_cyc   = 0;
      while (!done && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
         if (mem_ce) ce_cyc++;
         if (cpu_ready) done = 1;
      end
      cpu_rd = 1'b0;
      d = cpu_rdata;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL rd_timeout addr=%h got no cpu_ready, required ready within 50 cycles", a);
      end
      $display("rd addr=%h data=%h lat=%0d ce_cycles=%0d hit=%0d miss=%0d", a, d, lat, ce_cyc,
               hit_count, miss_count);
   endtask

   // Issue a write (optionally with cpu_rd also high); samples the RAM-side
   // outputs on the first cycle after the request is taken.
   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic also_rd,
                           output int lat, output logic ce_seen, output logic rw_seen,
                           output logic [31:0] wd_seen, output logic [7:0] ad_seen);
      bit done = 0;
      @(negedge clk);
      cpu_wr    = 1'b1;
      cpu_rd    = also_rd;
      cpu_addr  = a;
      cpu_wdata = d;
      lat       = 0;
      ce_seen   = 1'b0;
      rw_seen   = 1'b1;
      wd_seen   = '0;
      ad_seen   = '0;
      while (!done && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            ce_seen = mem_ce;
            rw_seen = mem_rw;
            wd_seen = mem_wdata;
            ad_seen = mem_addr;
         end
         if (cpu_ready) done = 1;
      end
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wr_timeout addr=%h got no cpu_ready, required ready within 50 cycles", a);
      end
      $display("wr addr=%h data=%h lat=%0d hit=%0d miss=%0d", a, d, lat, hit_count, miss_count);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int lat, ce;
      apply_reset();
      checks++;
      if ({cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_ce, mem_rw} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdata=%h rdy=%b maddr=%h mwd=%h ce=%b rw=%b, required all 0",
                  cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_ce, mem_rw);
      end
      checks++;
      if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_counts got hit=%0d miss=%0d, required 0/0", hit_count, miss_count);
      end
      // Start a miss, then abort it with reset while in FILL.
      @(negedge clk);
      cpu_rd   = 1'b1;
      cpu_addr = 8'h10;
      @(posedge clk);
      #1;
      checks++;
      if (mem_ce !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 8'h10) begin
         errors++;
         $display("FAIL fill_start got ce=%b rw=%b addr=%h, required 1/1/10", mem_ce, mem_rw, mem_addr);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_ce, mem_rw} !== '0 ||
          miss_count !== 16'd0) begin
         errors++;
         $display("FAIL async_reset got ce=%b addr=%h rdy=%b miss=%0d, required all 0",
                  mem_ce, mem_addr, cpu_ready, miss_count);
      end
      cpu_rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_read(8'h10, d, lat, ce);
      checks++;
      if (d !== 32'hA5A5_0010 || miss_count !== 16'd1 || ce == 0) begin
         errors++;
         $display("FAIL post_reset_read got data=%h miss=%0d ce=%0d, required A5A50010/1/>0",
                  d, miss_count, ce);
      end
   endtask

   task automatic test_cold_read_hit();
      logic [31:0] d;
      int lat, ce;
      apply_reset();
      do_read(8'h20, d, lat, ce);
      checks++;
      if (d !== 32'hDEAD_BEEF || ce != 3 || lat != 4) begin
         errors++;
         $display("FAIL cold_read got data=%h ce=%0d lat=%0d, required DEADBEEF/3/4", d, ce, lat);
      end
      do_read(8'h20, d, lat, ce);
      checks++;
      if (d !== 32'hDEAD_BEEF || ce != 0 || lat != 1) begin
         errors++;
         $display("FAIL read_hit got data=%h ce=%0d lat=%0d, required DEADBEEF/0/1", d, ce, lat);
      end
      checks++;
      if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
         errors++;
         $display("FAIL cold_counts got hit=%0d miss=%0d, required 1/1", hit_count, miss_count);
      end
   endtask

   task automatic test_lru();
      logic [31:0] d;
      int lat, ce;
      apply_reset();
      for (int i = 1; i <= 4; i++) begin
         do_read(8'(i), d, lat, ce);
      end
      do_read(8'h01, d, lat, ce);
      checks++;
      if (lat != 1 || d !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL lru_rehit01 got lat=%0d data=%h, required 1/A5A50001", lat, d);
      end
      do_read(8'h05, d, lat, ce);
      do_read(8'h02, d, lat, ce);
      checks++;
      if (ce == 0 || miss_count !== 16'd6 || d !== 32'hA5A5_0002) begin
         errors++;
         $display("FAIL lru_evict02 got ce=%0d miss=%0d data=%h, required >0/6/A5A50002",
                  ce, miss_count, d);
      end
      do_read(8'h01, d, lat, ce);
      checks++;
      if (lat != 1 || ce != 0 || hit_count !== 16'd2) begin
         errors++;
         $display("FAIL lru_keep01 got lat=%0d ce=%0d hit=%0d, required 1/0/2", lat, ce, hit_count);
      end
   endtask

   task automatic test_write();
      logic [31:0] d, wd;
      logic [7:0]  ad;
      logic        cs, rw;
      int lat, ce;
      apply_reset();
      do_write(8'h30, 32'h1234_5678, 1'b0, lat, cs, rw, wd, ad);
      checks++;
      if (cs !== 1'b1 || rw !== 1'b0 || wd !== 32'h1234_5678 || ad !== 8'h30 || lat != 4) begin
         errors++;
         $display("FAIL write_miss_bus got ce=%b rw=%b wd=%h addr=%h lat=%0d, required 1/0/12345678/30/4",
                  cs, rw, wd, ad, lat);
      end
      checks++;
      if (miss_count !== 16'd1 || ram[8'h30] !== 32'h1234_5678) begin
         errors++;
         $display("FAIL write_through got miss=%0d ram=%h, required 1/12345678", miss_count, ram[8'h30]);
      end
      do_read(8'h30, d, lat, ce);
      checks++;
      if (d !== 32'h1234_5678 || lat != 1 || hit_count !== 16'd1 || miss_count !== 16'd1) begin
         errors++;
         $display("FAIL write_alloc_read got data=%h lat=%0d hit=%0d miss=%0d, required 12345678/1/1/1",
                  d, lat, hit_count, miss_count);
      end
      do_write(8'h30, 32'hCAFE_F00D, 1'b0, lat, cs, rw, wd, ad);
      do_read(8'h30, d, lat, ce);
      checks++;
      if (d !== 32'hCAFE_F00D || lat != 1 || hit_count !== 16'd3 || miss_count !== 16'd1) begin
         errors++;
         $display("FAIL write_hit got data=%h lat=%0d hit=%0d miss=%0d, required CAFEF00D/1/3/1",
                  d, lat, hit_count, miss_count);
      end
   endtask

   task automatic test_priority_flush();
      logic [31:0] d, wd;
      logic [7:0]  ad;
      logic        cs, rw;
      int lat, ce;
      apply_reset();
      do_write(8'h40, 32'h0BAD_C0DE, 1'b1, lat, cs, rw, wd, ad);
      checks++;
      if (cs !== 1'b1 || rw !== 1'b0 || wd !== 32'h0BAD_C0DE) begin
         errors++;
         $display("FAIL wr_over_rd got ce=%b rw=%b wd=%h, required 1/0/0BADC0DE", cs, rw, wd);
      end
      do_read(8'h40, d, lat, ce);
      checks++;
      if (d !== 32'h0BAD_C0DE || lat != 1) begin
         errors++;
         $display("FAIL prio_readback got data=%h lat=%0d, required 0BADC0DE/1", d, lat);
      end
      @(negedge clk);
      cpu_flush = 1'b1;
      cpu_rd    = 1'b1;
      cpu_addr  = 8'h40;
      @(posedge clk);
      #1;
      cpu_flush = 1'b0;
      cpu_rd    = 1'b0;
      checks++;
      if (cpu_ready !== 1'b1 || mem_ce !== 1'b0 || hit_count !== 16'd1) begin
         errors++;
         $display("FAIL flush_ready got rdy=%b ce=%b hit=%0d, required 1/0/1", cpu_ready, mem_ce, hit_count);
      end
      $display("flush rdy=%b hit=%0d miss=%0d", cpu_ready, hit_count, miss_count);
      @(posedge clk);
      #1;
      checks++;
      if (cpu_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_pulse got rdy=%b one cycle later, required 0", cpu_ready);
      end
      do_read(8'h40, d, lat, ce);
      checks++;
      if (ce == 0 || d !== 32'h0BAD_C0DE || miss_count !== 16'd2) begin
         errors++;
         $display("FAIL flush_miss got ce=%0d data=%h miss=%0d, required >0/0BADC0DE/2", ce, d, miss_count);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      int lat, ce;
      apply_reset();
      do_read(8'h50, d, lat, ce);
      for (int i = 0; i < 5; i++) begin
         do_read(8'h50, d, lat, ce);
      end
      checks++;
      if (s_hit_count !== 2'd3 || s_miss_count !== 2'd1 || s_cpu_rdata !== 32'hA5A5_0050) begin
         errors++;
         $display("FAIL sat_hit got hit=%0d miss=%0d data=%h, required 3/1/A5A50050",
                  s_hit_count, s_miss_count, s_cpu_rdata);
      end
      checks++;
      if (hit_count !== 16'd5) begin
         errors++;
         $display("FAIL wide_hit got hit=%0d, required 5", hit_count);
      end
   endtask

   initial begin
      test_reset();
      test_cold_read_hit();
      test_lru();
      test_write();
      test_priority_flush();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
